// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Moore outputs are registered against the next state so they line up with the state register.
module multicycle_control #(
  parameter int unsigned MEM_WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_en,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ula_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [4:0] state_dbg
);

  localparam int unsigned CW = $clog2(MEM_WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT_CYCLES - 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef enum logic [4:0] {
    FETCH, FETCH_WAIT, DECODE, MEM_ADDR, MEM_READ, MEM_WAIT, MEM_WB, MEM_WRITE,
    R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, ILLEGAL
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  state_t        state, nst;
  logic [CW-1:0] cnt, ncnt;
  ctrl_t         ctrl, ctrl_g;

  function automatic state_t next_state(state_t st, logic [CW-1:0] c, logic [5:0] op);
    next_state = st;
    case (st)
      FETCH:      next_state = FETCH_WAIT;
      FETCH_WAIT: if (c == LAST) next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEM_ADDR;
          OP_R:         next_state = R_EXEC;
          OP_BEQ:       next_state = BRANCH;
          OP_J:         next_state = JUMP;
          OP_ADDI:      next_state = ADDI_EXEC;
          default:      next_state = ILLEGAL;
        endcase
      end
      MEM_ADDR:   next_state = (op == OP_SW) ? MEM_WRITE : MEM_READ;
      MEM_READ:   next_state = MEM_WAIT;
      MEM_WAIT:   if (c == LAST) next_state = MEM_WB;
      R_EXEC:     next_state = R_WB;
      ADDI_EXEC:  next_state = ADDI_WB;
      ILLEGAL:    next_state = ILLEGAL;
      default:    next_state = FETCH;
    endcase
  endfunction

  // Outputs of a state; 'last' marks the final wait cycle of FETCH_WAIT.
  function automatic ctrl_t decode(state_t st, logic last);
    decode = '0;
    case (st)
      FETCH: begin
        decode.pc_write  = 1'b1;
        decode.alu_src_b = 2'b01;
      end
      FETCH_WAIT: decode.ir_write = last;
      DECODE:     decode.alu_src_b = 2'b11;
      MEM_ADDR, ADDI_EXEC: begin
        decode.alu_src_a = 1'b1;
        decode.alu_src_b = 2'b10;
      end
      MEM_READ, MEM_WAIT: decode.i_or_d = 1'b1;
      MEM_WB: begin
        decode.mem_to_reg = 1'b1;
        decode.reg_write  = 1'b1;
      end
      MEM_WRITE: begin
        decode.i_or_d    = 1'b1;
        decode.mem_write = 1'b1;
      end
      R_EXEC: begin
        decode.alu_src_a = 1'b1;
        decode.ula_op    = 2'b10;
      end
      R_WB: begin
        decode.reg_dst   = 1'b1;
        decode.reg_write = 1'b1;
      end
      ADDI_WB: decode.reg_write = 1'b1;
      BRANCH: begin
        decode.alu_src_a     = 1'b1;
        decode.ula_op        = 2'b01;
        decode.pc_write_cond = 1'b1;
        decode.pc_source     = 2'b01;
      end
      JUMP: begin
        decode.pc_write  = 1'b1;
        decode.pc_source = 2'b10;
      end
      ILLEGAL: decode.illegal_op = 1'b1;
      default: decode = '0;
    endcase
  endfunction

  assign nst  = next_state(state, cnt, opcode);
  // Counter runs only while a wait state holds; any state change clears it.
  assign ncnt = ((nst == state) && ((state == FETCH_WAIT) || (state == MEM_WAIT)))
                ? cnt + CW'(1) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cnt   <= '0;
      ctrl  <= decode(FETCH, 1'b0);
    end else begin
      state <= nst;
      cnt   <= ncnt;
      ctrl  <= decode(nst, ncnt == LAST);
    end
  end

  assign ctrl_g        = reset ? '0 : ctrl;
  assign pc_write      = ctrl_g.pc_write;
  assign pc_write_cond = ctrl_g.pc_write_cond;
  assign pc_en         = ctrl_g.pc_write | (ctrl_g.pc_write_cond & zero);
  assign i_or_d        = ctrl_g.i_or_d;
  assign mem_write     = ctrl_g.mem_write;
  assign ir_write      = ctrl_g.ir_write;
  assign reg_dst       = ctrl_g.reg_dst;
  assign mem_to_reg    = ctrl_g.mem_to_reg;
  assign reg_write     = ctrl_g.reg_write;
  assign alu_src_a     = ctrl_g.alu_src_a;
  assign alu_src_b     = ctrl_g.alu_src_b;
  assign ula_op        = ctrl_g.ula_op;
  assign pc_source     = ctrl_g.pc_source;
  assign illegal_op    = ctrl_g.illegal_op;
  assign state_dbg     = reset ? 5'd0 : 5'(state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one instance with one memory wait cycle, one with two.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic [21:0] o1, o2;

  int errors;
  int checks;
  int iod_cnt;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic [16:0] e_fetch, e_fw0, e_fw1, e_dec, e_madr, e_mrd, e_mwb, e_mwr;
  logic [16:0] e_rex, e_rwb, e_aex, e_awb, e_br1, e_br0, e_jmp, e_ill;
  logic [16:0] t3 [9];

  multicycle_control #(.MEM_WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_en(o1[16]), .pc_write(o1[15]), .pc_write_cond(o1[14]), .i_or_d(o1[13]),
    .mem_write(o1[12]), .ir_write(o1[11]), .reg_dst(o1[10]), .mem_to_reg(o1[9]),
    .reg_write(o1[8]), .alu_src_a(o1[7]), .alu_src_b(o1[6:5]), .ula_op(o1[4:3]),
    .pc_source(o1[2:1]), .illegal_op(o1[0]), .state_dbg(o1[21:17])
  );

  multicycle_control #(.MEM_WAIT_CYCLES(2)) u2 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_en(o2[16]), .pc_write(o2[15]), .pc_write_cond(o2[14]), .i_or_d(o2[13]),
    .mem_write(o2[12]), .ir_write(o2[11]), .reg_dst(o2[10]), .mem_to_reg(o2[9]),
    .reg_write(o2[8]), .alu_src_a(o2[7]), .alu_src_b(o2[6:5]), .ula_op(o2[4:3]),
    .pc_source(o2[2:1]), .illegal_op(o2[0]), .state_dbg(o2[21:17])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: pc_en pc_write pc_write_cond i_or_d mem_write ir_write reg_dst mem_to_reg
  //              reg_write alu_src_a alu_src_b ula_op pc_source illegal_op
  function automatic logic [16:0] mk(input logic en, pw, pwc, iod, mw, irw, rd, m2r, rw, asa,
                                     input logic [1:0] asb, op, pcs, input logic ill);
    mk = {en, pw, pwc, iod, mw, irw, rd, m2r, rw, asa, asb, op, pcs, ill};
  endfunction

  task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic c1(input string tag, input logic [16:0] exp);
    chk(tag, {5'd0, o1[16:0]}, {5'd0, exp});
  endtask

  task automatic c2(input string tag, input logic [16:0] exp);
    chk(tag, {5'd0, o2[16:0]}, {5'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    iod_cnt = 0;
    reset = 1'b1;
    opcode = 6'h00;
    zero = 1'b0;

    e_fetch = mk(H,H,L,L,L,L,L,L,L,L,2'b01,2'b00,2'b00,L);
    e_fw0   = mk(L,L,L,L,L,L,L,L,L,L,2'b00,2'b00,2'b00,L);
    e_fw1   = mk(L,L,L,L,L,H,L,L,L,L,2'b00,2'b00,2'b00,L);
    e_dec   = mk(L,L,L,L,L,L,L,L,L,L,2'b11,2'b00,2'b00,L);
    e_madr  = mk(L,L,L,L,L,L,L,L,L,H,2'b10,2'b00,2'b00,L);
    e_mrd   = mk(L,L,L,H,L,L,L,L,L,L,2'b00,2'b00,2'b00,L);
    e_mwb   = mk(L,L,L,L,L,L,L,H,H,L,2'b00,2'b00,2'b00,L);
    e_mwr   = mk(L,L,L,H,H,L,L,L,L,L,2'b00,2'b00,2'b00,L);
    e_rex   = mk(L,L,L,L,L,L,L,L,L,H,2'b00,2'b10,2'b00,L);
    e_rwb   = mk(L,L,L,L,L,L,H,L,H,L,2'b00,2'b00,2'b00,L);
    e_aex   = mk(L,L,L,L,L,L,L,L,L,H,2'b10,2'b00,2'b00,L);
    e_awb   = mk(L,L,L,L,L,L,L,L,H,L,2'b00,2'b00,2'b00,L);
    e_br1   = mk(H,L,H,L,L,L,L,L,L,H,2'b00,2'b01,2'b01,L);
    e_br0   = mk(L,L,H,L,L,L,L,L,L,H,2'b00,2'b01,2'b01,L);
    e_jmp   = mk(H,H,L,L,L,L,L,L,L,L,2'b00,2'b00,2'b10,L);
    e_ill   = mk(L,L,L,L,L,L,L,L,L,L,2'b00,2'b00,2'b00,H);
    t3 = '{e_fw0, e_fw1, e_dec, e_madr, e_mrd, e_mrd, e_mrd, e_mwb, e_fetch};

    // T1: two reset cycles, everything forced low, then FETCH
    cyc();
    cyc();
    chk("t1_rst_u1", o1, 22'd0);
    chk("t1_rst_u2", o2, 22'd0);
    reset = 1'b0;
    #1;
    c1("t1_fetch_u1", e_fetch);
    c2("t1_fetch_u2", e_fetch);
    cyc(); c1("t1_irw", e_fw1); c2("t1_fw_first_n2", e_fw0);

    // T2: R-type, five cycles
    cyc(); c1("t2_dec", e_dec);
    cyc(); c1("t2_rexec", e_rex);
    cyc(); c1("t2_rwb", e_rwb);
    cyc(); c1("t2_ret", e_fetch);

    // addi
    opcode = 6'h08;
    cyc(); c1("addi_fw", e_fw1);
    cyc(); c1("addi_dec", e_dec);
    cyc(); c1("addi_exec", e_aex);
    cyc(); c1("addi_wb", e_awb);
    cyc(); c1("addi_ret", e_fetch);

    // sw: single write cycle then back to fetch
    opcode = 6'h2B;
    cyc(); cyc();
    cyc(); c1("sw_addr", e_madr);
    cyc(); c1("sw_write", e_mwr);
    cyc(); c1("sw_ret", e_fetch);

    // T4: beq with zero high and low
    opcode = 6'h04;
    cyc(); cyc(); c1("beq_dec", e_dec);
    cyc();
    zero = 1'b1; #1; c1("t4_beq_taken", e_br1);
    zero = 1'b0; #1; c1("t4_beq_not", e_br0);
    cyc(); c1("t4_ret", e_fetch);

    // jump
    opcode = 6'h02;
    cyc(); cyc();
    cyc(); c1("j_jump", e_jmp);
    cyc(); c1("j_ret", e_fetch);

    // lw with one wait cycle
    opcode = 6'h23;
    cyc(); c1("lw1_fw", e_fw1);
    cyc(); c1("lw1_dec", e_dec);
    cyc(); c1("lw1_addr", e_madr);
    cyc(); c1("lw1_read", e_mrd);
    cyc(); c1("lw1_wait", e_mrd);
    cyc(); c1("lw1_wb", e_mwb);
    cyc(); c1("lw1_ret", e_fetch);

    // T3: lw with two wait cycles on u2, nine cycles, three i_or_d cycles
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    c2("t3_fetch", e_fetch);
    iod_cnt = int'(o2[13]);
    for (int i = 0; i < 9; i++) begin
      cyc();
      c2($sformatf("t3_step%0d", i), t3[i]);
      if (i < 8) iod_cnt += int'(o2[13]);
    end
    chk("t3_iod_cycles", 22'(iod_cnt), 22'd3);

    // T6: reset during MEM_WAIT aborts the load
    cyc(); cyc(); cyc(); cyc(); cyc();
    cyc(); c2("t6_in_wait", e_mrd);
    reset = 1'b1;
    #1;
    chk("t6_rst_same", o2, 22'd0);
    cyc();
    chk("t6_rst_edge", o2, 22'd0);
    reset = 1'b0;
    opcode = 6'h3F;
    #1;
    c2("t6_fetch", e_fetch);

    // T5: unknown opcode halts in ILLEGAL until reset
    cyc(); c2("t5_fw0", e_fw0);
    cyc(); c2("t5_fw1", e_fw1);
    cyc(); c2("t5_dec", e_dec);
    for (int i = 0; i < 20; i++) begin
      cyc();
      c2($sformatf("t5_ill%0d", i), e_ill);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    c2("t5_recover", e_fetch);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
